// File: rtl/dmem_responder.sv
// Data-memory responder: latency-padded load/store on a word array.
// Optional macro DMEM_MISALIGN_TRAP_EN flags and suppresses misaligned accesses.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_R,
    input  logic        Mem_W,
    input  logic [2:0]  Data_T,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [2:0]    type_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          done_q;
    logic          misalign_q;

    logic [31:0]   mem_q [DEPTH];

    logic          req;
    logic          live;
    logic          fire;
    logic          op_we;
    logic [2:0]    op_t;
    logic [AW+1:0] op_a;
    logic [31:0]   op_wd;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic [1:0]    op_off;
    logic [AW-1:0] op_idx;
    logic          mis;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   word_w;
    logic [7:0]    byte_w;
    logic [15:0]   half_w;
    logic [31:0]   rdata_d;
    logic          unused_addr;

    assign req  = Mem_R | Mem_W;
    assign live = (state_q == IDLE);

    // The access fires on the edge into RESP; with no wait cycles that is
    // the accept edge itself, so the live inputs stand in for the captures.
    assign fire = (live && req && WAIT_CYCLES == 0)
               || (state_q == ACCESS && cnt_q == 4'd0);

    assign op_we  = live ? Mem_W : we_q;
    assign op_t   = live ? Data_T : type_q;
    assign op_a   = live ? addr[AW+1:0] : addr_q;
    assign op_wd  = live ? wdata : wdata_q;
    assign op_idx = op_a[AW+1:2];

    assign is_byte = (op_t[1:0] == 2'b00);
    assign is_half = (op_t[1:0] == 2'b01);
    assign is_word = op_t[1];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (is_half && op_a[0])
              || (is_word && op_a[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        op_off = 2'b00;
        be     = 4'b1111;
        wlane  = op_wd;
        unique case (1'b1)
            is_byte: begin
                op_off = op_a[1:0];
                be     = 4'b0001 << op_a[1:0];
                wlane  = {4{op_wd[7:0]}};
            end
            is_half: begin
                op_off = {op_a[1], 1'b0};
                be     = 4'b0011 << {op_a[1], 1'b0};
                wlane  = {2{op_wd[15:0]}};
            end
            is_word: begin
                op_off = 2'b00;
                be     = 4'b1111;
                wlane  = op_wd;
            end
            default: begin
                op_off = 2'b00;
            end
        endcase
    end

    assign word_w = mem_q[op_idx];
    assign byte_w = word_w[{op_off, 3'b000} +: 8];
    assign half_w = word_w[{op_off[1], 4'b0000} +: 16];

    always_comb begin
        rdata_d = word_w;
        unique case (1'b1)
            is_byte: rdata_d = {{24{~op_t[2] & byte_w[7]}}, byte_w};
            is_half: rdata_d = {{16{~op_t[2] & half_w[15]}}, half_w};
            is_word: rdata_d = word_w;
            default: rdata_d = word_w;
        endcase
    end

    // Contents are not reset; a reset edge must never commit a write.
    always_ff @(posedge clk) begin
        if (rst && fire && op_we && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[op_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            type_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= Mem_W;
                        type_q  <= Data_T;
                        addr_q  <= addr[AW+1:0];
                        wdata_q <= wdata;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= ACCESS;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (fire) begin
                done_q     <= 1'b1;
                misalign_q <= mis;
                if (!op_we && !mis) begin
                    rdata_q <= rdata_d;
                end
            end
        end
    end

    assign unused_addr = ^addr[31:AW+2];

    assign stall    = (live && req) || (state_q == ACCESS);
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instances with WAIT_CYCLES 2 and 0, checked
// against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int W_A   = 2;
    localparam int W_B   = 0;
    localparam int SPAN  = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_a = 1'b0, w_a = 1'b0, r_b = 1'b0, w_b = 1'b0;
    logic [2:0]  t_a = 3'b0, t_b = 3'b0;
    logic [31:0] ad_a = 32'd0, wd_a = 32'd0, ad_b = 32'd0, wd_b = 32'd0;
    logic [31:0] rd_a, rd_b;
    logic        st_a, dn_a, ms_a, st_b, dn_b, ms_b;

    int          ncmp = 0;
    int          nfail = 0;
    int unsigned cyc = 0;

    logic [7:0]  mdl_a [SPAN];
    logic [7:0]  mdl_b [SPAN];
    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst(rst), .Mem_R(r_a), .Mem_W(w_a), .Data_T(t_a),
        .addr(ad_a), .wdata(wd_a), .rdata(rd_a), .stall(st_a),
        .done(dn_a), .misalign(ms_a)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst(rst), .Mem_R(r_b), .Mem_W(w_b), .Data_T(t_b),
        .addr(ad_b), .wdata(wd_b), .rdata(rd_b), .stall(st_b),
        .done(dn_b), .misalign(ms_b)
    );

    task automatic drive(input bit b, input bit r, input bit w,
                         input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d);
        if (b) begin
            r_b = r; w_b = w; t_b = t; ad_b = a; wd_b = d;
        end else begin
            r_a = r; w_a = w; t_a = t; ad_a = a; wd_a = d;
        end
    endtask

    // Starts just after a rising edge; request fields are scrambled once
    // accepted, since only the captured values may matter.
    task automatic xact(input bit b, input bit r, input bit w,
                        input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, output int nst,
                        output int ndn, output logic [31:0] rd,
                        output logic ms);
        drive(b, r, w, t, a, d);
        nst = 0; ndn = -1; rd = 32'd0; ms = 1'b0;
        for (int c = 1; c <= 24 && ndn < 0; c++) begin
            @(negedge clk);
            if (b ? st_b : st_a) nst++;
            if (b ? dn_b : dn_a) begin
                ndn = c;
                rd  = b ? rd_b : rd_a;
                ms  = b ? ms_b : ms_a;
            end
            @(posedge clk); #1;
            if (ndn < 0) drive(b, r, w, 3'($urandom), $urandom, $urandom);
        end
        drive(b, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    function automatic int sz(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic model(input bit b, input bit w, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] erd, output logic ems);
        int n, ea;
        logic [31:0] v, mask;
        n  = sz(t);
        ea = int'(a % 32'(SPAN));
`ifdef DMEM_MISALIGN_TRAP_EN
        ems = (ea % n) != 0;
`else
        ems = 1'b0;
        ea  = ea - (ea % n);
`endif
        if (!ems) begin
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    if (b) mdl_b[ea+i] = d[8*i +: 8];
                    else   mdl_a[ea+i] = d[8*i +: 8];
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v[8*i +: 8] = b ? mdl_b[ea+i] : mdl_a[ea+i];
                if (n < 4 && !t[2]) begin
                    mask = (32'h1 << (8*n)) - 32'h1;
                    if (v[8*n-1]) v = v | ~mask;
                end
                if (b) exp_b = v;
                else   exp_a = v;
            end
        end
        erd = b ? exp_b : exp_a;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++; if (rd_a !== 32'd0) begin nfail++;
            $display("FAIL rst_rdata got %h want 0", rd_a); end
        ncmp++; if (dn_a !== 1'b0 || ms_a !== 1'b0) begin nfail++;
            $display("FAIL rst_done got %b/%b want 0/0", dn_a, ms_a); end
        ncmp++; if (st_a !== 1'b0 || st_b !== 1'b0) begin nfail++;
            $display("FAIL rst_stall got %b/%b want 0/0", st_a, st_b); end
        ncmp++; if (rd_b !== 32'd0) begin nfail++;
            $display("FAIL rst_rdata_b got %h want 0", rd_b); end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        ncmp++; if ({rd_a, dn_a, st_a} !== 34'd0) begin nfail++;
            $display("FAIL rel_out got %h/%b/%b want 0", rd_a, dn_a, st_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_init;
        int nst, ndn; logic [31:0] rd, erd, d; logic ms, ems;
        for (int k = 0; k < DEPTH; k++) begin
            d = $urandom;
            xact(1'b0, 1'b0, 1'b1, 3'b010, 32'(4*k), d, nst, ndn, rd, ms);
            model(1'b0, 1'b1, 3'b010, 32'(4*k), d, erd, ems);
            ncmp++; if (ndn != W_A + 2) begin nfail++;
                $display("FAIL init_a done_cycle got %0d want %0d", ndn, W_A+2); end
            d = $urandom;
            xact(1'b1, 1'b0, 1'b1, 3'b010, 32'(4*k), d, nst, ndn, rd, ms);
            model(1'b1, 1'b1, 3'b010, 32'(4*k), d, erd, ems);
            ncmp++; if (ndn != W_B + 2) begin nfail++;
                $display("FAIL init_b done_cycle got %0d want %0d", ndn, W_B+2); end
        end
    endtask

    task automatic test_extend;
        int nst, ndn; logic [31:0] rd, erd; logic ms, ems;
        logic [2:0]  tt [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] aa [5] = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] ee [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE,
                                32'hFFFFBEEF, 32'h0000DEAD};
        xact(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, nst, ndn, rd, ms);
        model(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, erd, ems);
        ncmp++; if (nst != 3 || ndn != 4) begin nfail++;
            $display("FAIL sw_timing got stall %0d done %0d want 3/4", nst, ndn); end
        for (int i = 0; i < 5; i++) begin
            xact(1'b0, 1'b1, 1'b0, tt[i], aa[i], 32'd0, nst, ndn, rd, ms);
            model(1'b0, 1'b0, tt[i], aa[i], 32'd0, erd, ems);
            ncmp++; if (rd !== ee[i]) begin nfail++;
                $display("FAIL ext_%0d rdata got %h want %h", i, rd, ee[i]); end
        end
    endtask

    task automatic test_partial;
        int nst, ndn; logic [31:0] rd, erd; logic ms, ems;
        logic [2:0]  tt [3] = '{3'b010, 3'b000, 3'b001};
        logic [31:0] aa [3] = '{32'h20, 32'h21, 32'h22};
        logic [31:0] dd [3] = '{32'h0, 32'hAB, 32'h1234};
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, 1'b0, 1'b1, tt[i], aa[i], dd[i], nst, ndn, rd, ms);
            model(1'b0, 1'b1, tt[i], aa[i], dd[i], erd, ems);
        end
        xact(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b010, 32'h20, 32'd0, erd, ems);
        ncmp++; if (rd !== 32'h1234AB00) begin nfail++;
            $display("FAIL partial rdata got %h want 1234ab00", rd); end
    endtask

    task automatic test_misalign;
        int nst, ndn; logic [31:0] rd, erd, w1, w2; logic ms, ems, em;
        xact(1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b000, 32'h10, 32'd0, erd, ems);
        ncmp++; if (rd !== 32'hFFFFFFEF) begin nfail++;
            $display("FAIL lb10 rdata got %h want ffffffef", rd); end
`ifdef DMEM_MISALIGN_TRAP_EN
        em = 1'b1; w1 = 32'hFFFFFFEF; w2 = 32'h1234AB00;
`else
        em = 1'b0; w1 = 32'h1234AB00; w2 = 32'hFFFFAB00;
`endif
        xact(1'b0, 1'b1, 1'b0, 3'b010, 32'h22, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b010, 32'h22, 32'd0, erd, ems);
        ncmp++; if (rd !== w1 || ms !== em || ndn != 4) begin nfail++;
            $display("FAIL lw22 got %h/%b/%0d want %h/%b/4", rd, ms, ndn, w1, em); end
        xact(1'b0, 1'b0, 1'b1, 3'b001, 32'h23, 32'hFFFF, nst, ndn, rd, ms);
        model(1'b0, 1'b1, 3'b001, 32'h23, 32'hFFFF, erd, ems);
        ncmp++; if (ms !== em) begin nfail++;
            $display("FAIL sh23 misalign got %b want %b", ms, em); end
        xact(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b010, 32'h20, 32'd0, erd, ems);
        ncmp++; if (rd !== w2) begin nfail++;
            $display("FAIL lw20 after sh23 got %h want %h", rd, w2); end
    endtask

    task automatic test_reset_mid;
        int nst, ndn; logic [31:0] rd, erd; logic ms, ems;
        xact(1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, nst, ndn, rd, ms);
        model(1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, erd, ems);
        xact(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b010, 32'h30, 32'd0, erd, ems);
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h55);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        exp_a = 32'd0; exp_b = 32'd0;
        ncmp++; if ({rd_a, dn_a, st_a, ms_a} !== 35'd0) begin nfail++;
            $display("FAIL midrst out got %h/%b/%b/%b want 0", rd_a, dn_a, st_a, ms_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0, nst, ndn, rd, ms);
        model(1'b0, 1'b0, 3'b010, 32'h30, 32'd0, erd, ems);
        ncmp++; if (rd !== 32'hCAFEF00D || ndn != 4 || nst != 3) begin nfail++;
            $display("FAIL midrst lw30 got %h/%0d/%0d want cafef00d/4/3", rd, ndn, nst); end
    endtask

    task automatic test_wait0;
        int nst, ndn; logic [31:0] rd, erd, prev, d; logic ms, ems;
        xact(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, nst, ndn, rd, ms);
        model(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, erd, ems);
        ncmp++; if (nst != 1 || ndn != 2 || rd !== erd) begin nfail++;
            $display("FAIL w0 lw got %0d/%0d/%h want 1/2/%h", nst, ndn, rd, erd); end
        prev = rd;
        d = $urandom;
        xact(1'b1, 1'b1, 1'b1, 3'b010, 32'h40, d, nst, ndn, rd, ms);
        model(1'b1, 1'b1, 3'b010, 32'h40, d, erd, ems);
        ncmp++; if (ndn != 2 || rd !== prev) begin nfail++;
            $display("FAIL w0 rw got %0d/%h want 2/%h", ndn, rd, prev); end
        xact(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, nst, ndn, rd, ms);
        model(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, erd, ems);
        ncmp++; if (rd !== d) begin nfail++;
            $display("FAIL w0 lw after rw got %h want %h", rd, d); end
    endtask

    task automatic test_back_to_back;
        int nst, ndn; logic [31:0] rd, erd, a; logic [2:0] t; logic ms, ems;
        int unsigned t0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; t = 3'($urandom);
            xact(1'b0, 1'b1, 1'b0, t, a, 32'd0, nst, ndn, rd, ms);
            model(1'b0, 1'b0, t, a, 32'd0, erd, ems);
            ncmp++; if (rd !== erd || ndn != W_A + 2) begin nfail++;
                $display("FAIL b2b_%0d got %h/%0d want %h/%0d", i, rd, ndn, erd, W_A+2); end
        end
        ncmp++; if (cyc - t0 != 4 * (W_A + 2)) begin nfail++;
            $display("FAIL b2b cycles got %0d want %0d", cyc - t0, 4*(W_A+2)); end
    endtask

    task automatic test_random;
        int nst, ndn, op, wc;
        logic [31:0] rd, erd, a, d; logic [2:0] t; logic ms, ems, b, r, w;
        for (int i = 0; i < 400; i++) begin
            b  = (i >= 300);
            wc = b ? W_B : W_A;
            op = int'($urandom_range(0, 2));
            r  = (op != 1); w = (op != 0);
            t  = w ? 3'($urandom_range(0, 2)) : 3'($urandom);
            a  = $urandom; d = $urandom;
            xact(b, r, w, t, a, d, nst, ndn, rd, ms);
            model(b, w, t, a, d, erd, ems);
            ncmp++; if (rd !== erd) begin nfail++;
                $display("FAIL rnd_%0d rdata got %h want %h", i, rd, erd); end
            ncmp++; if (ms !== ems) begin nfail++;
                $display("FAIL rnd_%0d misalign got %b want %b", i, ms, ems); end
            ncmp++; if (ndn != wc + 2 || nst != wc + 1) begin nfail++;
                $display("FAIL rnd_%0d timing got %0d/%0d want %0d/%0d",
                         i, nst, ndn, wc + 1, wc + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_extend();
        test_partial();
        test_misalign();
        test_reset_mid();
        test_wait0();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
